mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 8, RAM address width.
REQ-003 SHALL have parameter MEM_DATA_BITS, default 16, RAM data width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester access request.
REQ-007 SHALL have port req_we  input  NUM_REQ  per-requester write flag (1 = write).
REQ-008 SHALL have port req_addr  input  NUM_REQ*MEM_ADDR_BITS  flattened addresses, requester i at slice i.
REQ-009 SHALL have port req_wdata  input  NUM_REQ*MEM_DATA_BITS  flattened write data.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-hot completion pulse.
REQ-012 SHALL have port rsp_rdata  output  MEM_DATA_BITS  read data, valid with rsp_valid on a read.
REQ-013 SHALL have ports ram_en, ram_we  output  1 each; ram_addr  output  MEM_ADDR_BITS; ram_din  output  MEM_DATA_BITS; ram_dout  input  MEM_DATA_BITS, to the single-port RAM (1-cycle registered read).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-015 IDLE: if any req_valid, SHALL select a winner, pulse req_ready[winner] for one cycle, latch we/addr/wdata/winner, go to ISSUE; else stay IDLE.
REQ-016 ISSUE: SHALL drive ram_en=1 and ram_we/ram_addr/ram_din from latched registers (all RAM outputs registered); write -> IDLE, read -> WAIT.
REQ-017 Write completion: SHALL pulse rsp_valid[winner] in the ISSUE cycle.
REQ-018 WAIT: SHALL pulse rsp_valid[winner] with rsp_rdata=ram_dout, go to IDLE.
REQ-019 Latency: read accept->response 2 cycles; write accept->ack 1 cycle; one access outstanding at most.
REQ-020 Requesters hold valid/we/addr/wdata stable until req_ready; the arbiter SHALL sample only in the accept cycle.
REQ-021 No response backpressure: rsp_valid is a single-cycle pulse and SHALL NOT be repeated.
REQ-022 ram_en SHALL be 0 in IDLE and WAIT; ram_we SHALL be 0 whenever ram_en is 0.
REQ-023 rsp_rdata SHALL hold its last value when rsp_valid is 0.
REQ-024 Requester dropping req_valid before grant SHALL be ignored without side effects.

Reset
REQ-025 On rst: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, priority pointer=0.
REQ-026 Reset mid-operation SHALL abandon the in-flight access with no response; a write already in ISSUE may have completed in RAM.

Configuration
REQ-027 With MEM_ARB_RR_EN defined: round-robin; search starts at (last winner+1) mod NUM_REQ; pointer updates on each grant.
REQ-028 Without MEM_ARB_RR_EN: fixed priority, lowest index wins; no pointer register.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the FSM state enum and default width constants.
REQ-030 Winner selection SHALL be sub-module rr_arbiter (req vector in, one-hot grant out, MEM_ARB_RR_EN-controlled).

Verification
REQ-031 Single write: req 0 write addr 0x10 data 0xBEEF -> req_ready[0] at T, ram_en/ram_we at T+1 addr 0x10 din 0xBEEF, rsp_valid[0] at T+1.
REQ-032 Read-back: req 2 read 0x10 after REQ-031 -> rsp_valid[2] at T+2 with rsp_rdata=0xBEEF.
REQ-033 Contention (RR): requesters 0..3 all valid reading 0x00..0x03 -> grants 0,1,2,3 at 3-cycle spacing; with macro undefined and requesters held, 0 wins repeatedly.
REQ-034 Pointer wrap: last grant 3, requesters 0 and 3 valid -> 0 granted next.
REQ-035 Reset mid-read: assert rst in WAIT -> no rsp_valid, all outputs 0 next edge, IDLE.
REQ-036 Idle: no req_valid for 10 cycles -> ram_en, req_ready, rsp_valid stay 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state type and default widths shared by mem_arbiter and rr_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot winner select; round-robin when MEM_ARB_RR_EN is defined, else fixed priority (lowest index)
module rr_arbiter import mem_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
`ifdef MEM_ARB_RR_EN
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
`ifdef MEM_ARB_RR_EN
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] ptr, ptr_nxt;
    logic found;
    // search from ptr upward, then wrap around to the low indices
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k] && k >= int'(ptr)) begin
                grant[k] = 1'b1;
                ptr_nxt  = PW'((k + 1) % NUM_REQ);
                found    = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                ptr_nxt  = PW'((k + 1) % NUM_REQ);
                found    = 1'b1;
            end
        end
    end
    // ptr is the first index to consider on the next grant (last winner + 1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= ptr_nxt;
    end
`else
    logic found;
    // lowest requesting index wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM (1-cycle registered read) among NUM_REQ requesters, one access in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int MEM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int MEM_DATA_BITS = DEF_DATA_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*MEM_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQ*MEM_DATA_BITS-1:0] req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [MEM_DATA_BITS-1:0]         rsp_rdata,
    output logic                             ram_en,
    output logic                             ram_we,
    output logic [MEM_ADDR_BITS-1:0]         ram_addr,
    output logic [MEM_DATA_BITS-1:0]         ram_din,
    input  logic [MEM_DATA_BITS-1:0]         ram_dout
);
    state_t state, state_nxt;
    logic [NUM_REQ-1:0] grant, winner;
    logic accept, sel_we;
    logic [MEM_ADDR_BITS-1:0] sel_addr;
    logic [MEM_DATA_BITS-1:0] sel_wdata, rdata_q;

    assign accept = (state == IDLE) && |req_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .advance(accept),
`endif
        .req    (req_valid),
        .grant  (grant)
    );

    // route the granted requester's command fields (grant is one-hot)
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*MEM_ADDR_BITS +: MEM_ADDR_BITS];
                sel_wdata = req_wdata[i*MEM_DATA_BITS +: MEM_DATA_BITS];
            end
        end
    end

    // next state and handshake outputs; writes ack in ISSUE, reads return RAM data in WAIT
    always_comb begin
        state_nxt = state;
        req_ready = accept ? grant : '0;
        rsp_valid = '0;
        rsp_rdata = rdata_q;
        case (state)
            IDLE: if (accept) state_nxt = ISSUE;
            ISSUE: begin
                state_nxt = ram_we ? IDLE : WAIT;
                if (ram_we) rsp_valid = winner;
            end
            WAIT: begin
                state_nxt = IDLE;
                rsp_valid = winner;
                rsp_rdata = ram_dout;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // accepted command is latched straight into the RAM port registers, so ram_en is high exactly in ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner   <= '0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rdata_q  <= '0;
        end else begin
            ram_en <= accept;
            ram_we <= accept & sel_we;
            if (accept) begin
                winner   <= grant;
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
            end
            if (state == WAIT)
                rdata_q <= ram_dout;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural single-port RAM (1-cycle registered read)
module tb_mem_arbiter;
    localparam int N = 4, AW = 8, DW = 16;

    typedef struct {
        int            cyc;
        int            idx;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid = '0, req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata, ram_din, ram_dout;
    logic ram_en, ram_we;
    logic [AW-1:0] ram_addr;

    ev_t ram_q[$], rsp_q[$];
    int exp_grant[$];
    logic [DW-1:0] mem [256];
    bit wr [256];
    logic [DW-1:0] ref_mem [int];
    logic [AW-1:0] drv_addr [N];
    logic [DW-1:0] drv_wdata [N];
    bit drv_we [N];
    logic [DW-1:0] last_rdata = '0;
    int n_chk = 0, n_err = 0, cyc_n = 0, hold0 = 0;

    mem_arbiter #(.NUM_REQ(N), .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed(logic [AW-1:0] a);
        return 16'hA000 | DW'(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                wr[ram_addr]  <= 1'b1;
            end
            ram_dout <= wr[ram_addr] ? mem[ram_addr] : seed(ram_addr);
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed(a);
    endfunction

    task automatic monitor();
        ev_t e;
        int g;
        if (rst) begin
            check("rst_ctl", {req_ready, rsp_valid, ram_en, ram_we}, 0);
            check("rst_data", {rsp_rdata, ram_addr, ram_din}, 0);
            ram_q.delete();
            rsp_q.delete();
            last_rdata = '0;
            return;
        end
        if (ram_q.size() != 0 && ram_q[0].cyc == cyc_n) begin
            e = ram_q.pop_front();
            check("ram_ctl", {ram_en, ram_we}, {1'b1, e.we});
            check("ram_addr", ram_addr, e.addr);
            if (e.we) check("ram_din", ram_din, e.data);
        end else begin
            check("ram_ctl", {ram_en, ram_we}, 2'b00);
        end
        if (rsp_q.size() != 0 && rsp_q[0].cyc == cyc_n) begin
            e = rsp_q.pop_front();
            check("rsp_valid", rsp_valid, N'(1) << e.idx);
            if (!e.we) begin
                check("rsp_rdata", rsp_rdata, e.data);
                last_rdata = e.data;
            end
        end else begin
            check("rsp_valid", rsp_valid, 0);
            check("rsp_hold", rsp_rdata, last_rdata);
        end
        if (req_ready != 0) begin
            g = 0;
            for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
            if (exp_grant.size() != 0) check("grant", req_ready, N'(1) << exp_grant.pop_front());
            else check("grant", req_ready, 0);
            e.idx  = g;
            e.we   = drv_we[g];
            e.addr = drv_addr[g];
            e.data = drv_wdata[g];
            e.cyc  = cyc_n + 1;
            ram_q.push_back(e);
            if (e.we) begin
                ref_mem[int'(e.addr)] = e.data;
            end else begin
                e.data = ref_read(e.addr);
                e.cyc  = cyc_n + 2;
            end
            rsp_q.push_back(e);
        end
    endtask

    // one clock: check outputs mid-cycle, then release requesters that were accepted
    task automatic tick();
        logic [N-1:0] rdy;
        @(negedge clk);
        cyc_n++;
        monitor();
        rdy = req_ready;
        @(posedge clk);
        #1;
        if (rdy[0] && hold0 > 0) begin
            hold0--;
            rdy[0] = 1'b0;
        end
        req_valid = req_valid & ~rdy;
    endtask

    task automatic drive(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i]            = 1'b1;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
        drv_we[i]    = we;
        drv_addr[i]  = a;
        drv_wdata[i] = d;
    endtask

    task automatic drain();
        int k = 0;
        while ((req_valid != 0 || exp_grant.size() != 0 || rsp_q.size() != 0 || ram_q.size() != 0) && k < 40) begin
            tick();
            k++;
        end
        check("drain_timeout", {63'b0, k >= 40}, 0);
        exp_grant.delete();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;

        drive(0, 1'b1, 8'h10, 16'hBEEF);
        exp_grant.push_back(0);
        drain();

        drive(2, 1'b0, 8'h10, 16'h0);
        exp_grant.push_back(2);
        drain();

        for (int i = 0; i < N; i++) drive(i, 1'b0, AW'(i), 16'h0);
`ifdef MEM_ARB_RR_EN
        exp_grant = '{0, 1, 2, 3};
`else
        hold0 = 2;
        exp_grant = '{0, 0, 0, 1, 2, 3};
`endif
        drain();

        drive(0, 1'b0, 8'h05, 16'h0);
        drive(3, 1'b1, 8'h05, 16'h1234);
        exp_grant = '{0, 3};
        drain();
        drive(1, 1'b0, 8'h05, 16'h0);
        exp_grant.push_back(1);
        drain();

        drive(2, 1'b0, 8'h10, 16'h0);
        exp_grant.push_back(2);
        tick();
        drive(1, 1'b0, 8'h03, 16'h0);
        tick();
        req_valid[1] = 1'b0;
        drain();

        repeat (10) begin
            tick();
            check("idle_ready", req_ready, 0);
        end

        drive(1, 1'b0, 8'h03, 16'h0);
        exp_grant.push_back(1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_async_rsp", rsp_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_no_grant_left", exp_grant.size(), 0);

        drive(3, 1'b1, 8'hFF, 16'h5A5A);
        exp_grant.push_back(3);
        drain();
        drive(0, 1'b0, 8'hFF, 16'h0);
        exp_grant.push_back(0);
        drain();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
